// File: rtl/rob_retire.sv
// rob_retire: in-order ROB completion tracker with multi-lane retirement and branch squash.
// Optional macro ROB_RETIRE_BYPASS_EN merges same-cycle completions into the retire view.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

module rob_retire #(
    parameter  int unsigned ROB_SIZE = 32,
    parameter  int unsigned WAYS     = `SUPERSCALAR_WAYS,
    parameter  int unsigned PR_W     = 6,
    parameter  int unsigned XLEN     = `XLEN,
    localparam int unsigned IDX_W    = $clog2(ROB_SIZE),
    localparam int unsigned PTR_W    = IDX_W + 1,
    localparam int unsigned PKT_W    = 1 + IDX_W + XLEN + 1 + XLEN
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [WAYS-1:0]         dispatch_valid,
    input  logic [WAYS*PR_W-1:0]    dispatch_pr_idx,
    output logic                    dispatch_ready,
    output logic [WAYS*IDX_W-1:0]   dispatch_rob_idx,
    input  logic [WAYS*PKT_W-1:0]   complete_rob_in,
    output logic [WAYS-1:0]         retire_valid,
    output logic [WAYS*PR_W-1:0]    retire_pr_idx,
    output logic [WAYS*XLEN-1:0]    retire_value,
    output logic                    squash,
    output logic [XLEN-1:0]         squash_pc,
    output logic [IDX_W:0]          free_count
);

    typedef struct packed {
        logic             complete;
        logic [IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]  dest_value;
        logic             precise_state_enable;
        logic [XLEN-1:0]  target_pc;
    } cpl_pkt_t;

    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_done;
    logic [ROB_SIZE-1:0] r_br;
    logic [PR_W-1:0]     r_pr    [ROB_SIZE];
    logic [XLEN-1:0]     r_value [ROB_SIZE];
    logic [XLEN-1:0]     r_tpc   [ROB_SIZE];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;

    cpl_pkt_t            w_cpl    [WAYS];
    logic [IDX_W-1:0]    w_didx   [WAYS];
    logic [IDX_W-1:0]    w_ridx   [WAYS];
    logic                w_v_done [WAYS];
    logic                w_v_br   [WAYS];
    logic [XLEN-1:0]     w_v_val  [WAYS];
    logic [XLEN-1:0]     w_v_tpc  [WAYS];
    logic [WAYS-1:0]     w_ret;
    logic [PTR_W-1:0]    w_n_ret;
    logic [PTR_W-1:0]    w_n_disp;
    logic [PTR_W-1:0]    w_occ;
    logic                w_squash;
    logic [XLEN-1:0]     w_squash_pc;
    logic                w_go;

    // Unpack completion lanes and compute dispatch slot indices.
    always_comb begin
        for (int l = 0; l < int'(WAYS); l++) begin
            w_cpl[l] = cpl_pkt_t'(complete_rob_in[l*PKT_W +: PKT_W]);
        end
        w_n_disp = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            w_didx[i] = r_tail[IDX_W-1:0] + IDX_W'(i);
            dispatch_rob_idx[i*IDX_W +: IDX_W] = w_didx[i];
            w_n_disp = w_n_disp + PTR_W'(dispatch_valid[i]);
        end
    end

    always_comb begin
        w_occ          = r_tail - r_head;
        free_count     = PTR_W'(ROB_SIZE) - w_occ;
        dispatch_ready = (free_count >= PTR_W'(WAYS));
    end

    // Completion view of the head window; same-cycle completions merge in when bypass is built.
    always_comb begin
        for (int k = 0; k < int'(WAYS); k++) begin
            w_ridx[k]   = r_head[IDX_W-1:0] + IDX_W'(k);
            w_v_done[k] = r_done[w_ridx[k]];
            w_v_br[k]   = r_br[w_ridx[k]];
            w_v_val[k]  = r_value[w_ridx[k]];
            w_v_tpc[k]  = r_tpc[w_ridx[k]];
`ifdef ROB_RETIRE_BYPASS_EN
            for (int l = 0; l < int'(WAYS); l++) begin
                if (w_cpl[l].complete && (w_cpl[l].rob_idx == w_ridx[k])) begin
                    w_v_done[k] = 1'b1;
                    w_v_br[k]   = w_cpl[l].precise_state_enable;
                    w_v_val[k]  = w_cpl[l].dest_value;
                    w_v_tpc[k]  = w_cpl[l].target_pc;
                end
            end
`endif
        end
    end

    // Retire group: consecutive done entries from head, ending at the first taken branch.
    always_comb begin
        w_go          = 1'b1;
        w_ret         = '0;
        w_n_ret       = '0;
        w_squash      = 1'b0;
        w_squash_pc   = '0;
        retire_pr_idx = '0;
        retire_value  = '0;
        for (int k = 0; k < int'(WAYS); k++) begin
            if (w_go && r_valid[w_ridx[k]] && w_v_done[k]) begin
                w_ret[k]                       = 1'b1;
                w_n_ret                        = w_n_ret + PTR_W'(1);
                retire_pr_idx[k*PR_W +: PR_W]  = r_pr[w_ridx[k]];
                retire_value[k*XLEN +: XLEN]   = w_v_val[k];
                if (w_v_br[k]) begin
                    w_squash    = 1'b1;
                    w_squash_pc = w_v_tpc[k];
                    w_go        = 1'b0;
                end
            end else begin
                w_go = 1'b0;
            end
        end
        retire_valid = w_ret;
        squash       = w_squash;
        squash_pc    = w_squash_pc;
    end

    // Entry state and pointers; completions, then retire clears, then new allocations.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_br    <= '0;
            for (int e = 0; e < int'(ROB_SIZE); e++) begin
                r_pr[e]    <= '0;
                r_value[e] <= '0;
                r_tpc[e]   <= '0;
            end
        end else if (w_squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_br    <= '0;
        end else begin
            for (int l = 0; l < int'(WAYS); l++) begin
                if (w_cpl[l].complete && r_valid[w_cpl[l].rob_idx]) begin
                    r_done[w_cpl[l].rob_idx]  <= 1'b1;
                    r_br[w_cpl[l].rob_idx]    <= w_cpl[l].precise_state_enable;
                    r_value[w_cpl[l].rob_idx] <= w_cpl[l].dest_value;
                    r_tpc[w_cpl[l].rob_idx]   <= w_cpl[l].target_pc;
                end
            end
            for (int k = 0; k < int'(WAYS); k++) begin
                if (w_ret[k]) begin
                    r_valid[w_ridx[k]] <= 1'b0;
                    r_done[w_ridx[k]]  <= 1'b0;
                    r_br[w_ridx[k]]    <= 1'b0;
                end
            end
            if (dispatch_ready) begin
                for (int i = 0; i < int'(WAYS); i++) begin
                    if (dispatch_valid[i]) begin
                        r_valid[w_didx[i]] <= 1'b1;
                        r_done[w_didx[i]]  <= 1'b0;
                        r_br[w_didx[i]]    <= 1'b0;
                        r_pr[w_didx[i]]    <= dispatch_pr_idx[i*PR_W +: PR_W];
                    end
                end
                r_tail <= r_tail + w_n_disp;
            end
            r_head <= r_head + w_n_ret;
        end
    end

endmodule
